// File: rtl/exe_stage_if.sv
// Decode->execute->memory stage bus for exe_stage, including the ALU request/response and forwarding taps.
// master: the surrounding pipeline (decode, ALU, memory stage). slave: exe_stage.
interface exe_stage_if;
    logic        ds_to_es_valid;
    logic        es_allowin;
    logic [31:0] ds_pc;
    logic [11:0] ds_alu_op;
    logic [31:0] ds_rj_value;
    logic [31:0] ds_rkd_value;
    logic [31:0] ds_imm;
    logic        ds_src1_is_pc;
    logic        ds_src2_is_imm;
    logic        ds_src2_is_4;
    logic        ds_gr_we;
    logic [4:0]  ds_dest;
    logic        es_flush;
    logic [11:0] alu_op;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [31:0] alu_result;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [31:0] es_pc;
    logic [31:0] es_result;
    logic [4:0]  es_dest;
    logic        es_gr_we;
    logic        es_fwd_we;
    logic [4:0]  es_fwd_dest;

    modport master (
        output ds_to_es_valid, ds_pc, ds_alu_op, ds_rj_value, ds_rkd_value, ds_imm,
               ds_src1_is_pc, ds_src2_is_imm, ds_src2_is_4, ds_gr_we, ds_dest,
               es_flush, alu_result, ms_allowin,
        input  es_allowin, alu_op, alu_src1, alu_src2, es_to_ms_valid,
               es_pc, es_result, es_dest, es_gr_we, es_fwd_we, es_fwd_dest
    );

    modport slave (
        input  ds_to_es_valid, ds_pc, ds_alu_op, ds_rj_value, ds_rkd_value, ds_imm,
               ds_src1_is_pc, ds_src2_is_imm, ds_src2_is_4, ds_gr_we, ds_dest,
               es_flush, alu_result, ms_allowin,
        output es_allowin, alu_op, alu_src1, alu_src2, es_to_ms_valid,
               es_pc, es_result, es_dest, es_gr_we, es_fwd_we, es_fwd_dest
    );
endinterface

// File: rtl/exe_stage.sv
// Execute pipeline stage: holds one instruction, feeds the external ALU and hands results to memory stage.
// Define ES_RESULT_REG_EN to register the ALU result (CALC/DONE phase, 2-cycle latency).
module exe_stage (
    input logic        clk,
    input logic        reset,
    exe_stage_if.slave bus
);
    logic        es_valid_q, es_valid_d;
    logic        es_ready_go, es_allowin, capture, to_ms;
    logic [31:0] pc_q, rj_q, rkd_q, imm_q;
    logic [11:0] op_q;
    logic [4:0]  dest_q;
    logic        src1_is_pc_q, src2_is_imm_q, src2_is_4_q, gr_we_q;

    assign es_allowin = ~es_valid_q | (es_ready_go & bus.ms_allowin);
    assign capture    = bus.ds_to_es_valid & es_allowin & ~bus.es_flush;
    assign to_ms      = es_valid_q & es_ready_go & ~bus.es_flush;

    // Flush wins over a same-cycle capture so nothing enters behind it.
    always_comb begin
        es_valid_d = es_valid_q;
        if (bus.es_flush)    es_valid_d = 1'b0;
        else if (es_allowin) es_valid_d = bus.ds_to_es_valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) es_valid_q <= 1'b0;
        else       es_valid_q <= es_valid_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= '0;
            op_q          <= '0;
            rj_q          <= '0;
            rkd_q         <= '0;
            imm_q         <= '0;
            src1_is_pc_q  <= 1'b0;
            src2_is_imm_q <= 1'b0;
            src2_is_4_q   <= 1'b0;
            gr_we_q       <= 1'b0;
            dest_q        <= '0;
        end else if (capture) begin
            pc_q          <= bus.ds_pc;
            op_q          <= bus.ds_alu_op;
            rj_q          <= bus.ds_rj_value;
            rkd_q         <= bus.ds_rkd_value;
            imm_q         <= bus.ds_imm;
            src1_is_pc_q  <= bus.ds_src1_is_pc;
            src2_is_imm_q <= bus.ds_src2_is_imm;
            src2_is_4_q   <= bus.ds_src2_is_4;
            gr_we_q       <= bus.ds_gr_we;
            dest_q        <= bus.ds_dest;
        end
    end

`ifdef ES_RESULT_REG_EN
    typedef enum logic {CALC = 1'b0, DONE = 1'b1} phase_e;
    phase_e      phase_q, phase_d;
    logic [31:0] es_result_r;
    logic        res_load;

    always_comb begin
        phase_d  = phase_q;
        res_load = 1'b0;
        case (phase_q)
            CALC: if (es_valid_q & ~bus.es_flush) begin
                phase_d  = DONE;
                res_load = 1'b1;
            end
            DONE: if ((to_ms & bus.ms_allowin) | bus.es_flush) phase_d = CALC;
            default: phase_d = CALC;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q     <= CALC;
            es_result_r <= '0;
        end else begin
            phase_q <= phase_d;
            if (res_load) es_result_r <= bus.alu_result;
        end
    end

    assign es_ready_go   = (phase_q == DONE);
    assign bus.es_result = es_result_r;
`else
    assign es_ready_go   = 1'b1;
    assign bus.es_result = bus.alu_result;
`endif

    assign bus.es_allowin     = es_allowin;
    assign bus.es_to_ms_valid = to_ms;
    assign bus.alu_op         = op_q & {12{es_valid_q}};
    assign bus.alu_src1       = src1_is_pc_q ? pc_q : rj_q;
    assign bus.alu_src2       = src2_is_4_q ? 32'd4 : (src2_is_imm_q ? imm_q : rkd_q);
    assign bus.es_pc          = pc_q;
    assign bus.es_dest        = dest_q;
    assign bus.es_gr_we       = gr_we_q;
    assign bus.es_fwd_we      = es_valid_q & gr_we_q & (dest_q != 5'd0);
    assign bus.es_fwd_dest    = dest_q;
endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: expected results are queued on acceptance and checked on hand-off.
module tb_exe_stage;
`ifdef ES_RESULT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] res;
        logic [4:0]  dest;
        logic        we;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_out = 0;
    int   gaps[$];
    exp_t sb[$];
    logic m_valid;

    always #5 clk = ~clk;

    exe_stage_if bus();
    exe_stage dut (.clk(clk), .reset(reset), .bus(bus));

    function automatic logic [31:0] alu(logic [11:0] op, logic [31:0] a, logic [31:0] b);
        if (op[0]) return a + b;
        if (op[1]) return a - b;
        if (op[2]) return a | b;
        return 32'd0;
    endfunction

    always_comb bus.alu_result = alu(bus.alu_op, bus.alu_src1, bus.alu_src2);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference occupancy for the single-cycle build.
    always @(posedge clk or posedge reset) begin
        if (reset)                       m_valid <= 1'b0;
        else if (bus.es_flush)           m_valid <= 1'b0;
        else if (!m_valid || bus.ms_allowin) m_valid <= bus.ds_to_es_valid;
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.es_to_ms_valid && bus.ms_allowin) begin
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_pc", bus.es_pc, e.pc);
                    chk("sb_res", bus.es_result, e.res);
                    chk("sb_dest_we", {26'd0, bus.es_gr_we, bus.es_dest}, {26'd0, e.we, e.dest});
                end
                gaps.push_back(cyc - last_out);
                last_out = cyc;
            end
            if (bus.ds_to_es_valid && bus.es_allowin && !bus.es_flush) begin
                exp_t e;
                logic [31:0] s1, s2;
                s1 = bus.ds_src1_is_pc ? bus.ds_pc : bus.ds_rj_value;
                s2 = bus.ds_src2_is_4 ? 32'd4 : (bus.ds_src2_is_imm ? bus.ds_imm : bus.ds_rkd_value);
                e.pc = bus.ds_pc;
                e.res = alu(bus.ds_alu_op, s1, s2);
                e.dest = bus.ds_dest;
                e.we = bus.ds_gr_we;
                sb.push_back(e);
            end
`ifndef ES_RESULT_REG_EN
            chk("allowin_model", 32'(bus.es_allowin), 32'(!m_valid || bus.ms_allowin));
`endif
        end
    end

    task automatic set_instr(input logic [31:0] pc, input logic [11:0] op, input logic [31:0] rj,
                             input logic [31:0] rkd, input logic [31:0] imm, input logic s1pc,
                             input logic s2imm, input logic s24, input logic we, input logic [4:0] dest);
        bus.ds_pc = pc;          bus.ds_alu_op = op;
        bus.ds_rj_value = rj;    bus.ds_rkd_value = rkd;   bus.ds_imm = imm;
        bus.ds_src1_is_pc = s1pc; bus.ds_src2_is_imm = s2imm; bus.ds_src2_is_4 = s24;
        bus.ds_gr_we = we;       bus.ds_dest = dest;
        bus.ds_to_es_valid = 1'b1;
    endtask

    // Holds the instruction until accepted; returns just after the accepting edge.
    task automatic send(input logic [31:0] pc, input logic [11:0] op, input logic [31:0] rj,
                        input logic [31:0] rkd, input logic [31:0] imm, input logic s1pc,
                        input logic s2imm, input logic s24, input logic we, input logic [4:0] dest);
        logic ok;
        set_instr(pc, op, rj, rkd, imm, s1pc, s2imm, s24, we, dest);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.es_allowin) ok = 1'b1;
            @(posedge clk); #1;
        end
        chk("send_accept", 32'(ok), 32'd1);
    endtask

    task automatic idle();
        bus.ds_to_es_valid = 1'b0;
    endtask

    // Leaves the caller on the negedge where es_to_ms_valid is seen.
    task automatic wait_out(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.es_to_ms_valid && n < 8) begin
            n++;
            @(negedge clk);
        end
        chk(tag, n, LAT - 1);
    endtask

    initial begin
        set_instr('0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        bus.ds_to_es_valid = 1'b0;
        bus.es_flush = 1'b0;
        bus.ms_allowin = 1'b1;

        @(negedge clk);
        chk("rst_to_ms", 32'(bus.es_to_ms_valid), 32'd0);
        chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
        chk("rst_fwd_we", 32'(bus.es_fwd_we), 32'd0);
        chk("rst_pc", bus.es_pc, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("allowin_after_rst", 32'(bus.es_allowin), 32'd1);
        @(posedge clk); #1;

        // add rj=5 + imm=7
        send(32'h1000, 12'h001, 32'd5, 32'd0, 32'd7, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3);
        idle();
        wait_out("lat_add");
        chk("add_alu_op", 32'(bus.alu_op), 32'h001);
        chk("add_src1", bus.alu_src1, 32'd5);
        chk("add_src2", bus.alu_src2, 32'd7);
        chk("add_result", bus.es_result, 32'd12);
        chk("add_to_ms", 32'(bus.es_to_ms_valid), 32'd1);
        @(posedge clk); #1;

        // src2_is_4 beats src2_is_imm
        send(32'h2000, 12'h001, 32'd0, 32'd0, 32'h100, 1'b1, 1'b1, 1'b1, 1'b1, 5'd7);
        idle();
        wait_out("lat_pc4");
        chk("is4_src2", bus.alu_src2, 32'd4);
        chk("is4_src1", bus.alu_src1, 32'h2000);
        chk("is4_result", bus.es_result, 32'h2004);
        @(posedge clk); #1;

        // forwarding: r0 never forwarded, gr_we=0 never forwarded
        send(32'h3000, 12'h001, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        idle();
        wait_out("lat_r0");
        chk("fwd_r0_we", 32'(bus.es_fwd_we), 32'd0);
        @(posedge clk); #1;
        send(32'h3004, 12'h002, 32'd9, 32'd4, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5);
        idle();
        wait_out("lat_r5");
        chk("fwd_r5_we", 32'(bus.es_fwd_we), 32'd1);
        chk("fwd_r5_dest", 32'(bus.es_fwd_dest), 32'd5);
        chk("sub_result", bus.es_result, 32'd5);
        @(posedge clk); #1;
        send(32'h3008, 12'h001, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5);
        idle();
        wait_out("lat_nowe");
        chk("fwd_nowe", 32'(bus.es_fwd_we), 32'd0);
        @(posedge clk); #1;

        // stall: A held three cycles while B waits at the input
        bus.ms_allowin = 1'b0;
        send(32'h4000, 12'h004, 32'd3, 32'hC, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9);
        set_instr(32'h4004, 12'h001, 32'd10, 32'd20, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd10);
        wait_out("lat_stall");
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            chk("stall_allowin", 32'(bus.es_allowin), 32'd0);
            chk("stall_pc", bus.es_pc, 32'h4000);
            chk("stall_src2", bus.alu_src2, 32'hC);
            chk("stall_result", bus.es_result, 32'hF);
            chk("stall_to_ms", 32'(bus.es_to_ms_valid), 32'd1);
        end
        @(posedge clk); #1 bus.ms_allowin = 1'b1;
        @(negedge clk);
        chk("release_allowin", 32'(bus.es_allowin), 32'd1);
        chk("release_to_ms", 32'(bus.es_to_ms_valid), 32'd1);
        @(posedge clk); #1 idle();
        @(negedge clk);
        chk("next_pc", bus.es_pc, 32'h4004);
        @(posedge clk); #1;
        repeat (LAT) @(posedge clk);
        #1;

        // flush together with an offered instruction on an empty stage
        set_instr(32'h6000, 12'h001, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4);
        bus.es_flush = 1'b1;
        @(negedge clk);
        chk("flush_in_to_ms", 32'(bus.es_to_ms_valid), 32'd0);
        @(posedge clk); #1 bus.es_flush = 1'b0; idle();
        @(negedge clk);
        chk("flush_in_to_ms2", 32'(bus.es_to_ms_valid), 32'd0);
        chk("flush_in_alu_op", 32'(bus.alu_op), 32'd0);
        chk("flush_in_allowin", 32'(bus.es_allowin), 32'd1);
        @(posedge clk); #1;

        // flush of a held instruction
        bus.ms_allowin = 1'b0;
        send(32'h6100, 12'h001, 32'd2, 32'd2, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6);
        idle();
        bus.es_flush = 1'b1;
        @(negedge clk);
        chk("flush_held_to_ms", 32'(bus.es_to_ms_valid), 32'd0);
        @(posedge clk); #1 bus.es_flush = 1'b0;
        @(negedge clk);
        chk("flush_held_alu_op", 32'(bus.alu_op), 32'd0);
        chk("flush_held_allowin", 32'(bus.es_allowin), 32'd1);
        chk("flush_held_sb", sb.size(), 32'd1);
        sb.delete();
        @(posedge clk); #1 bus.ms_allowin = 1'b1;

        // reset in the middle of a stall
        bus.ms_allowin = 1'b0;
        send(32'h7000, 12'h001, 32'd8, 32'd8, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8);
        idle();
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_to_ms", 32'(bus.es_to_ms_valid), 32'd0);
        chk("mid_rst_alu_op", 32'(bus.alu_op), 32'd0);
        chk("mid_rst_fwd_we", 32'(bus.es_fwd_we), 32'd0);
        chk("mid_rst_pc", bus.es_pc, 32'd0);
        chk("mid_rst_result", bus.es_result, 32'd0);
        chk("mid_rst_allowin", 32'(bus.es_allowin), 32'd1);
        sb.delete();
        @(posedge clk); #1 reset = 1'b0; bus.ms_allowin = 1'b1;

        // four back-to-back instructions after reset
        gaps.delete();
        for (int i = 0; i < 4; i++)
            send(32'h5000 + 32'(4 * i), 12'h001, 32'(i), 32'd0, 32'd16, 1'b0, 1'b1, 1'b0, 1'b1, 5'(i + 1));
        idle();
        for (int i = 0; i < 20 && gaps.size() < 4; i++) @(posedge clk);
        chk("burst_cnt", gaps.size(), 32'd4);
        for (int i = 1; i < 4 && i < gaps.size(); i++) chk("burst_gap", gaps[i], LAT);
        repeat (3) @(posedge clk);
        chk("sb_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
